// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: instruction fetch with req/ack memory port, prefetch FIFO and redirect flush.
// Optional macro IF_MISALIGN_TRAP_EN: sticky misalign trap on unaligned redirect targets.
module if_prefetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              start_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              misalign
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] mem_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_next;
    logic [CNT_W-1:0]  count, count_next;
    logic              pop, push, head_from_push, trap_next;
    logic [ADDR_W-1:0] target, pc_inc;

    assign target      = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign pc_inc      = imem_addr + ADDR_W'(4);
    // A redirect flushes the FIFO, so neither a pop nor the acked data survive it.
    assign pop         = inst_valid & inst_ready & ~redirect;
    assign push        = (state == REQ) & imem_ack & ~redirect;
    assign count_next  = count + CNT_W'(push) - CNT_W'(pop);
    assign rd_ptr_next = rd_ptr + PTR_W'(pop);
    assign head_from_push = push & ((count - CNT_W'(pop)) == '0);

`ifdef IF_MISALIGN_TRAP_EN
    assign trap_next = redirect ? (redirect_pc[1:0] != 2'b00) : misalign;

    always_ff @(posedge clk or negedge start_n) begin
        if (!start_n) misalign <= 1'b0;
        else          misalign <= trap_next;
    end
`else
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^redirect_pc[1:0];
    assign trap_next      = 1'b0;
    assign misalign       = 1'b0;
`endif

    // Storage needs no reset: only entries below count are ever presented.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]   <= imem_addr;
        end
    end

    always_ff @(posedge clk or negedge start_n) begin
        if (!start_n) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            inst_valid <= 1'b0;
            inst_data  <= '0;
            inst_pc    <= '0;
        end else if (redirect) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            inst_valid <= 1'b0;
            fetch_pc   <= target;
            if (state != IDLE && !imem_ack) begin
                // Old request still in flight: hold it and throw its data away.
                state <= DISCARD;
            end else if (trap_next) begin
                state    <= IDLE;
                imem_req <= 1'b0;
            end else begin
                state     <= REQ;
                imem_req  <= 1'b1;
                imem_addr <= target;
            end
        end else begin
            rd_ptr     <= rd_ptr_next;
            count      <= count_next;
            inst_valid <= (count_next != '0);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (head_from_push) begin
                inst_data <= imem_rdata;
                inst_pc   <= imem_addr;
            end else if (count_next != '0) begin
                inst_data <= mem_data[rd_ptr_next];
                inst_pc   <= mem_pc[rd_ptr_next];
            end

            case (state)
                IDLE: begin
                    if (count < DEPTH_C && !misalign) begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        fetch_pc <= pc_inc;
                        // Issue the next fetch only if its slot is free after this push/pop.
                        if (count_next < DEPTH_C) begin
                            imem_addr <= pc_inc;
                        end else begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        if (misalign) begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end else begin
                            state     <= REQ;
                            imem_addr <= fetch_pc;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb_if_prefetch_unit: queue-based fetch model checked every cycle, plus directed scenarios
// and randomized ready/latency/redirect traffic.
module tb_if_prefetch_unit;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk = 1'b0, start_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0, inst_valid, inst_ready = 1'b0;
    logic        redirect = 1'b0, misalign;
    logic [31:0] imem_addr, imem_rdata = '0, inst_data, inst_pc, redirect_pc = '0;

    int total = 0, bad = 0, cyc = 0;
    int lat_lo = 0, lat_hi = 0, cur_lat = 0, wait_cnt = 0;

    typedef struct packed {logic [31:0] pc; logic [31:0] data;} ent_t;
    ent_t        q[$];
    ent_t        cons_q[$];
    int          cons_cyc[$];
    logic [31:0] m_pc, m_addr;
    bit          m_out, m_stale, m_trap;

    always #5 clk = ~clk;

    if_prefetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk(clk), .start_n(start_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .misalign(misalign)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: one outstanding fetch, a queue of buffered words.
    task automatic model_step();
        bit was_full, pop, trap_n;
        was_full = (q.size() >= DEPTH);
        pop      = (q.size() > 0) && inst_ready && !redirect;
        if (redirect) begin
            q.delete();
`ifdef IF_MISALIGN_TRAP_EN
            trap_n = (redirect_pc[1:0] != 2'b00);
`else
            trap_n = 1'b0;
`endif
            m_pc = {redirect_pc[31:2], 2'b00};
            if (m_out && !imem_ack) m_stale = 1'b1;
            else begin
                m_stale = 1'b0;
                m_out   = !trap_n;
                if (m_out) m_addr = m_pc;
            end
            m_trap = trap_n;
        end else begin
            if (pop) void'(q.pop_front());
            if (m_out && imem_ack) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                    m_out   = !m_trap;
                    if (m_out) m_addr = m_pc;
                end else begin
                    q.push_back({m_addr, imem_rdata});
                    m_pc  = m_addr + 32'd4;
                    m_out = (q.size() < DEPTH);
                    if (m_out) m_addr = m_pc;
                end
            end else if (!m_out && !was_full && !m_trap) begin
                m_out  = 1'b1;
                m_addr = m_pc;
            end
        end
    endtask

    task automatic compare();
        if (!start_n) begin
            check("rst_req", 32'(imem_req), 32'd0);
            check("rst_addr", imem_addr, RST_PC);
            check("rst_valid", 32'(inst_valid), 32'd0);
            check("rst_data", inst_data, 32'd0);
            check("rst_pc", inst_pc, 32'd0);
            check("rst_misalign", 32'(misalign), 32'd0);
        end else begin
            check("req", 32'(imem_req), 32'(m_out));
            if (m_out) check("addr", imem_addr, m_addr);
            check("valid", 32'(inst_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                check("pc", inst_pc, q[0].pc);
                check("data", inst_data, q[0].data);
            end
            check("misalign", 32'(misalign), 32'(m_trap));
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!start_n) begin
            q.delete();
            m_pc = RST_PC; m_addr = RST_PC;
            m_out = 1'b0; m_stale = 1'b0; m_trap = 1'b0;
        end else begin
            if (inst_valid && inst_ready && !redirect) begin
                cons_q.push_back({inst_pc, inst_data});
                cons_cyc.push_back(cyc);
            end
            model_step();
        end
        #1;
        compare();
    end

    // Memory responder: acks after cur_lat wait cycles, data is a hash of the address.
    always @(negedge clk) begin
        if (!start_n || !imem_req) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt >= cur_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = memf(imem_addr);
            wait_cnt   = 0;
            cur_lat    = $urandom_range(lat_hi, lat_lo);
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            wait_cnt++;
        end
    end

    task automatic set_lat(input int lo, input int hi);
        lat_lo = lo; lat_hi = hi; cur_lat = lo;
    endtask

    task automatic do_reset();
        @(negedge clk);
        start_n  = 1'b0;
        redirect = 1'b0;
        repeat (3) @(negedge clk);
        start_n = 1'b1;
        cons_q.delete();
        cons_cyc.delete();
    endtask

    task automatic wait_cons(input int n, input int budget);
        int k = 0;
        while (cons_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_cons", 32'(cons_q.size() >= n), 32'd1);
    endtask

    task automatic check_cons(input int i, input logic [31:0] pc);
        if (cons_q.size() > i) begin
            check("cons_pc", cons_q[i].pc, pc);
            check("cons_data", cons_q[i].data, memf(pc));
        end
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        cons_q.delete();
        cons_cyc.delete();
        @(negedge clk);
        redirect = 1'b0;
    endtask

    initial begin
        // Streaming with zero-latency ack.
        inst_ready = 1'b1; set_lat(0, 0);
        do_reset();
        wait_cons(6, 50);
        for (int i = 0; i < 6; i++) check_cons(i, 32'(4 * i));
        if (cons_cyc.size() >= 6) check("stream_rate", 32'(cons_cyc[5] - cons_cyc[0]), 32'd5);

        // Backpressure: four entries buffer up, fetch stops, then drains in order.
        inst_ready = 1'b0;
        do_reset();
        repeat (10) @(negedge clk);
        check("bp_req", 32'(imem_req), 32'd0);
        check("bp_valid", 32'(inst_valid), 32'd1);
        check("bp_head", inst_pc, 32'h0);
        inst_ready = 1'b1;
        wait_cons(5, 50);
        for (int i = 0; i < 5; i++) check_cons(i, 32'(4 * i));

        // Fixed three-cycle ack latency.
        set_lat(3, 3);
        do_reset();
        wait_cons(8, 100);
        for (int i = 0; i < 8; i++) check_cons(i, 32'(4 * i));

        // Redirect while the fetch of address 8 is outstanding.
        set_lat(3, 3);
        do_reset();
        for (int k = 0; k < 60 && !(imem_req && imem_addr == 32'h8); k++) @(negedge clk);
        check("saw_addr8", 32'(imem_req && imem_addr == 32'h8), 32'd1);
        pulse_redirect(32'h100);
        wait_cons(3, 60);
        for (int i = 0; i < 3; i++) check_cons(i, 32'h100 + 32'(4 * i));

        // Redirect in the same cycle as ack and pop with two entries buffered.
        inst_ready = 1'b0; set_lat(0, 0);
        do_reset();
        repeat (3) @(negedge clk);
        check("pre_flush_valid", 32'(inst_valid), 32'd1);
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        cons_q.delete(); cons_cyc.delete();
        @(posedge clk); #2;
        check("flush_valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        wait_cons(1, 20);
        check_cons(0, 32'h40);

        // Misaligned redirect target.
        inst_ready = 1'b1; set_lat(1, 1);
        do_reset();
        repeat (4) @(negedge clk);
        pulse_redirect(32'h42);
`ifdef IF_MISALIGN_TRAP_EN
        repeat (8) @(negedge clk);
        check("trap_set", 32'(misalign), 32'd1);
        check("trap_req", 32'(imem_req), 32'd0);
        check("trap_cons", 32'(cons_q.size()), 32'd0);
        pulse_redirect(32'h80);
        wait_cons(1, 20);
        check_cons(0, 32'h80);
        check("trap_clr", 32'(misalign), 32'd0);
`else
        wait_cons(1, 20);
        check_cons(0, 32'h40);
        check("no_trap", 32'(misalign), 32'd0);
`endif

        // Randomized traffic; the last round sits near the top of the address space to hit wrap.
        for (int r = 0; r < 4; r++) begin
            set_lat(0, r);
            do_reset();
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                inst_ready = ($urandom_range(3, 0) >= (r % 3));
                redirect   = ($urandom_range(15, 0) == 0);
                if (r == 3) redirect_pc = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
                else        redirect_pc = $urandom & 32'h3FF;
            end
        end

        @(negedge clk);
        redirect = 1'b0;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
